mem_bus_resp: RTL and testbench
===============================

// Module: mem_bus_resp
// PURPOSE
//  Memory-module responder on the system bus: the far end of the CPU bus-control
//  cycles (read/write requests carrying NB, address and data).
//  - Translates (nb, ad[15:12]) through a segment map to a physical 4K-word frame.
//  - Performs the access on frame RAM and answers with a 4-phase handshake.
//  - Answers ok (done) or en (refused / segment not present).
//  - Also accepts map-configuration writes.
// PARAMETERS
//  FRAMES   16  physical 4K-word frames fitted (1..16)
//  WAIT      2  access wait cycles spent in ACCESS (1..15)
// PORTS
//  clk_sys     in   1   system clock
//  clr         in   1   reset, asynchronous, active-high
//  bus_w       in   1   write request (synchronous to clk_sys)
//  bus_r       in   1   read request
//  bus_cfg     in   1   qualifies bus_w as map-configuration cycle
//  bus_nb      in   4   block number
//  bus_ad      in   16  word address
//  bus_dt_in   in   16  write data / cfg word
//  bus_ok      out  1   cycle completed
//  bus_en      out  1   cycle refused
//  bus_dt_out  out  16  read data, valid while bus_ok high, else 0
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset (clr high, async):
//   - state IDLE; bus_ok, bus_en, bus_dt_out, busy = 0.
//   - All map entries invalid, except (nb=0, page=0), hardwired valid -> frame 0.
//   - RAM contents are untouched.
//  States: IDLE -> DECODE -> ACCESS -> ANSWER -> IDLE.
//  IDLE:
//   - On (bus_w ^ bus_r): latch nb, ad, dt, and cycle type; go to DECODE.
//   - On bus_w & bus_r (protocol violation): go straight to ANSWER with en; no access.
//  DECODE (1 cycle):
//   - Look up map[{nb, ad[15:12]}].
//   - Invalid entry -> ANSWER with en.
//   - Valid entry -> ACCESS with physical address {frame, ad[11:0]}.
//   - If the request drops during DECODE: abort to IDLE; no write, no answer.
//  ACCESS (WAIT cycles, down-counter):
//   - Write is committed on the first ACCESS cycle.
//   - Read data is captured on the last ACCESS cycle.
//   - If the request drops during ACCESS: the committed write stays; return to
//     IDLE without answering.
//  ANSWER:
//   - Drive exactly one of bus_ok / bus_en (plus bus_dt_out on an ok read).
//   - Hold until bus_w = bus_r = 0, then deassert everything next cycle and enter IDLE.
//   - No new request is accepted before IDLE.
//  Latency:
//   - Request sampled high at cycle 0; bus_ok first high at cycle WAIT+2.
//   - bus_en for an unmapped segment at cycle 2; for w&r at cycle 1.
//  Cfg cycle (bus_cfg & bus_w); the word is decoded from bus_dt_in:
//   - Fields: [15:12] page, [11:8] frame, [7:4] nb, [0] valid.
//   - Entry updated during DECODE; answered ok at cycle 2.
//   - frame >= FRAMES -> en, map unchanged.
//   - Target (nb=0, page=0) -> ok, map unchanged (hardwired).
//   - bus_cfg with bus_r -> en.
//   - bus_ad is ignored on cfg cycles.
//  Widths: no arithmetic on addresses beyond concatenation; the counter saturates
//  at 0, never wraps.
// STRUCTURE
//  Shared package mem_bus_pkg:
//   - state encoding;
//   - NB_BITS=4, PAGE_BITS=4, OFF_BITS=12;
//   - cfg field positions (CFG_PAGE, CFG_FRAME, CFG_NB, CFG_V).
//  Sub-module mem_frame_ram:
//   - single-port synchronous RAM, FRAMES*4096 x 16;
//   - 1-cycle read, write-enable, no reset.
//  Map (256 x 5 bits) lives in this module as a register array.
// TESTING
//  1 clr; r nb=0 ad=0x0010 -> ok at cycle 4 (WAIT=2), dt_out = RAM[0x0010];
//    drop r -> ok=0 next cycle.
//  2 w nb=3 ad=0x2005 dt=0xBEEF, map empty -> en at cycle 2; RAM unchanged;
//    release -> en=0.
//  3 cfg dt=0x2131 (page2, frame1, nb3, valid) -> ok; then w nb=3 ad=0x2005
//    dt=0xBEEF -> ok; r -> 0xBEEF.
//  4 w&r both high at nb=0 ad=0 -> en at cycle 1, no RAM write.
//  5 cfg frame=0xF with FRAMES=4 -> en, map unchanged;
//    cfg on nb0/page0 -> ok, still frame 0.
//  6 w dropped during DECODE -> no write, back to IDLE;
//    w dropped in ACCESS -> word written, no ok;
//    clr mid-ANSWER -> ok=0 immediately, map reset.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and field positions for the memory-module bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    ANSWER = 2'd3
  } state_t;

  localparam int NB_BITS   = 4;
  localparam int PAGE_BITS = 4;
  localparam int OFF_BITS  = 12;
  localparam int FRM_BITS  = 4;
  localparam int MAP_IDX_W = NB_BITS + PAGE_BITS;

  // Field lsb positions inside a map-configuration word.
  localparam int CFG_PAGE  = 12;
  localparam int CFG_FRAME = 8;
  localparam int CFG_NB    = 4;
  localparam int CFG_V     = 0;

  typedef struct packed {
    logic                 is_wr;
    logic                 is_cfg;
    logic [NB_BITS-1:0]   nb;
    logic [15:0]          ad;
    logic [15:0]          dt;
  } req_t;

  function automatic logic [MAP_IDX_W-1:0] map_idx(input logic [NB_BITS-1:0] nb,
                                                   input logic [PAGE_BITS-1:0] page);
    return {nb, page};
  endfunction

endpackage

// File: rtl/mem_frame_ram.sv
// Single-port frame RAM: synchronous write, registered 1-cycle read, no reset.
module mem_frame_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_resp.sv
// Bus-side memory responder: segment-map translation, frame RAM access and
// 4-phase ok/en handshake, plus map-configuration cycles.
module mem_bus_resp
  import mem_bus_pkg::*;
#(
  parameter int FRAMES = 16,
  parameter int WAIT   = 2
) (
  input  logic        clk_sys,
  input  logic        clr,
  input  logic        bus_w,
  input  logic        bus_r,
  input  logic        bus_cfg,
  input  logic [3:0]  bus_nb,
  input  logic [15:0] bus_ad,
  input  logic [15:0] bus_dt_in,
  output logic        bus_ok,
  output logic        bus_en,
  output logic [15:0] bus_dt_out,
  output logic        busy
);

  localparam int FB    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int AW    = FB + OFF_BITS;
  localparam int CW    = $clog2(WAIT + 1);
  localparam int ENTRS = 1 << MAP_IDX_W;

  state_t            state;
  req_t              req;
  logic [AW-1:0]     phys;
  logic [CW-1:0]     cnt;
  logic              first;

  logic              map_v [ENTRS];
  logic [FRM_BITS-1:0] map_f [ENTRS];

  logic [MAP_IDX_W-1:0] idx, cfg_idx;
  logic                 hit_v;
  logic [FRM_BITS-1:0]  hit_f;
  logic [FRM_BITS-1:0]  cfg_frame;
  logic                 cfg_ok, map_we, live, ram_we;
  logic [AW-1:0]        ram_addr;
  logic [15:0]          ram_rdata;

  // Entry (nb=0, page=0) is hardwired valid -> frame 0 regardless of the array.
  assign idx   = map_idx(req.nb, req.ad[15:12]);
  assign hit_v = (idx == '0) ? 1'b1 : map_v[idx];
  assign hit_f = (idx == '0) ? '0 : map_f[idx];

  assign cfg_frame = req.dt[CFG_FRAME +: FRM_BITS];
  assign cfg_idx   = map_idx(req.dt[CFG_NB +: NB_BITS], req.dt[CFG_PAGE +: PAGE_BITS]);
  assign cfg_ok    = req.is_wr && (int'(cfg_frame) < FRAMES);

  assign live   = req.is_wr ? bus_w : bus_r;
  assign map_we = (state == DECODE) && live && req.is_cfg && cfg_ok && (cfg_idx != '0);

  // Present the translated address already in DECODE so read data is ready
  // on the first ACCESS cycle even when WAIT is 1.
  assign ram_addr = (state == DECODE) ? {hit_f[FB-1:0], req.ad[OFF_BITS-1:0]} : phys;
  assign ram_we   = (state == ACCESS) && first && req.is_wr && !req.is_cfg;

  assign busy = (state != IDLE);

  mem_frame_ram #(.DEPTH(FRAMES * 4096), .AW(AW)) u_ram (
    .clk   (clk_sys),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (req.dt),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < ENTRS; i++) begin
        map_v[i] <= 1'b0;
        map_f[i] <= '0;
      end
    end else if (map_we) begin
      map_v[cfg_idx] <= req.dt[CFG_V];
      map_f[cfg_idx] <= cfg_frame;
    end
  end

  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      req        <= '0;
      phys       <= '0;
      cnt        <= '0;
      first      <= 1'b0;
      bus_ok     <= 1'b0;
      bus_en     <= 1'b0;
      bus_dt_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_w && bus_r) begin
            bus_en <= 1'b1;
            state  <= ANSWER;
          end else if (bus_w ^ bus_r) begin
            req.is_wr  <= bus_w;
            req.is_cfg <= bus_cfg;
            req.nb     <= bus_nb;
            req.ad     <= bus_ad;
            req.dt     <= bus_dt_in;
            state      <= DECODE;
          end
        end
        DECODE: begin
          if (!live) begin
            state <= IDLE;
          end else if (req.is_cfg) begin
            if (cfg_ok) bus_ok <= 1'b1;
            else        bus_en <= 1'b1;
            state <= ANSWER;
          end else if (!hit_v) begin
            bus_en <= 1'b1;
            state  <= ANSWER;
          end else begin
            phys  <= ram_addr;
            cnt   <= CW'(WAIT - 1);
            first <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          first <= 1'b0;
          if (!live) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            bus_ok     <= 1'b1;
            bus_dt_out <= req.is_wr ? 16'h0 : ram_rdata;
            state      <= ANSWER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ANSWER: begin
          if (!bus_w && !bus_r) begin
            bus_ok     <= 1'b0;
            bus_en     <= 1'b0;
            bus_dt_out <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_resp.sv
// Directed bench for mem_bus_resp: vector table of bus cycles plus hand-written
// abort / reset-during-answer sequences.
module tb_mem_bus_resp;

  localparam int FRAMES = 4;
  localparam int WAIT   = 2;
  localparam int LOK    = WAIT + 2;

  logic        clk_sys = 1'b0;
  logic        clr = 1'b0;
  logic        bus_w = 1'b0, bus_r = 1'b0, bus_cfg = 1'b0;
  logic [3:0]  bus_nb = '0;
  logic [15:0] bus_ad = '0, bus_dt_in = '0;
  logic        bus_ok, bus_en, busy;
  logic [15:0] bus_dt_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  mem_bus_resp #(.FRAMES(FRAMES), .WAIT(WAIT)) dut (
    .clk_sys    (clk_sys),
    .clr        (clr),
    .bus_w      (bus_w),
    .bus_r      (bus_r),
    .bus_cfg    (bus_cfg),
    .bus_nb     (bus_nb),
    .bus_ad     (bus_ad),
    .bus_dt_in  (bus_dt_in),
    .bus_ok     (bus_ok),
    .bus_en     (bus_en),
    .bus_dt_out (bus_dt_out),
    .busy       (busy)
  );

  typedef struct {
    bit          w, r, c;
    logic [3:0]  nb;
    logic [15:0] ad, dt;
    bit          eok, een;
    int          elat;
    logic [15:0] edt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit w, bit r, bit c, logic [3:0] nb, logic [15:0] ad,
                              logic [15:0] dt, bit eok, bit een, int elat, logic [15:0] edt);
    vec_t t;
    t.w = w; t.r = r; t.c = c; t.nb = nb; t.ad = ad; t.dt = dt;
    t.eok = eok; t.een = een; t.elat = elat; t.edt = edt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_idle"}, {bus_ok, bus_en, busy, bus_dt_out}, 32'h0);
  endtask

  // Called at a negedge; issues one full 4-phase cycle and checks it.
  task automatic txn(input vec_t t, input string nm);
    int lat;
    bus_w = t.w; bus_r = t.r; bus_cfg = t.c;
    bus_nb = t.nb; bus_ad = t.ad; bus_dt_in = t.dt;
    lat = 0;
    do begin
      @(posedge clk_sys); lat++; @(negedge clk_sys);
    end while (!(bus_ok || bus_en) && lat < 20);
    chk({nm, "_lat"}, lat, t.elat);
    chk({nm, "_resp"}, {bus_ok, bus_en, busy, bus_dt_out},
        {t.eok, t.een, 1'b1, t.edt});
    @(posedge clk_sys); @(negedge clk_sys);
    chk({nm, "_hold"}, {bus_ok, bus_en, bus_dt_out}, {t.eok, t.een, t.edt});
    bus_w = 1'b0; bus_r = 1'b0; bus_cfg = 1'b0;
    @(posedge clk_sys); @(negedge clk_sys);
    idle_chk(nm);
  endtask

  initial begin
    bit seen;
    // nb=0/page=0 is always mapped; prime frame 0 before the reset pulse.
    tbl.push_back(mk(1,0,0, 4'd0, 16'h0010, 16'h1234, 1,0, LOK, 16'h0));
    tbl.push_back(mk(1,0,0, 4'd0, 16'h0005, 16'h5555, 1,0, LOK, 16'h0));
    tbl.push_back(mk(1,0,0, 4'd0, 16'h0000, 16'h0A0A, 1,0, LOK, 16'h0));
    // index 3: clr pulse happens before this one; RAM must survive
    tbl.push_back(mk(0,1,0, 4'd0, 16'h0010, 16'h0,    1,0, LOK, 16'h1234));
    tbl.push_back(mk(1,0,0, 4'd3, 16'h2005, 16'hBEEF, 0,1, 2,   16'h0));
    tbl.push_back(mk(0,1,0, 4'd0, 16'h0005, 16'h0,    1,0, LOK, 16'h5555));
    tbl.push_back(mk(1,0,1, 4'd0, 16'hFFFF, 16'h2131, 1,0, 2,   16'h0));
    tbl.push_back(mk(1,0,0, 4'd3, 16'h2005, 16'hBEEF, 1,0, LOK, 16'h0));
    tbl.push_back(mk(0,1,0, 4'd3, 16'h2005, 16'h0,    1,0, LOK, 16'hBEEF));
    tbl.push_back(mk(1,0,1, 4'd0, 16'h0000, 16'h2F31, 0,1, 2,   16'h0));
    tbl.push_back(mk(1,0,1, 4'd0, 16'h0000, 16'h2431, 0,1, 2,   16'h0));
    tbl.push_back(mk(0,1,0, 4'd3, 16'h2005, 16'h0,    1,0, LOK, 16'hBEEF));
    tbl.push_back(mk(1,0,1, 4'd0, 16'h0000, 16'h0101, 1,0, 2,   16'h0));
    tbl.push_back(mk(0,1,0, 4'd0, 16'h0005, 16'h0,    1,0, LOK, 16'h5555));
    tbl.push_back(mk(0,1,1, 4'd0, 16'h0000, 16'h2131, 0,1, 2,   16'h0));
    tbl.push_back(mk(1,0,1, 4'd0, 16'h0000, 16'h2130, 1,0, 2,   16'h0));
    tbl.push_back(mk(0,1,0, 4'd3, 16'h2005, 16'h0,    0,1, 2,   16'h0));
    tbl.push_back(mk(1,1,0, 4'd0, 16'h0000, 16'hDEAD, 0,1, 1,   16'h0));
    tbl.push_back(mk(0,1,0, 4'd0, 16'h0000, 16'h0,    1,0, LOK, 16'h0A0A));
    tbl.push_back(mk(1,0,0, 4'd0, 16'h0020, 16'h2222, 1,0, LOK, 16'h0));

    #2 clr = 1'b1;
    repeat (2) @(negedge clk_sys);
    idle_chk("reset");
    clr = 1'b0;
    @(negedge clk_sys);

    foreach (tbl[i]) begin
      if (i == 3) begin
        #2 clr = 1'b1;
        @(negedge clk_sys);
        idle_chk("reset2");
        clr = 1'b0;
        @(negedge clk_sys);
      end
      txn(tbl[i], $sformatf("v%0d", i));
    end

    // Write dropped while in DECODE: no write, no answer.
    bus_w = 1'b1; bus_nb = 4'd0; bus_ad = 16'h0020; bus_dt_in = 16'h1111;
    @(posedge clk_sys); @(negedge clk_sys);
    chk("dec_busy", busy, 1'b1);
    bus_w = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (bus_ok || bus_en) seen = 1'b1;
    end
    chk("dec_noans", {seen, busy}, 2'b00);
    txn(mk(0,1,0, 4'd0, 16'h0020, 16'h0, 1,0, LOK, 16'h2222), "dec_rd");

    // Write dropped during ACCESS: word committed, no answer.
    bus_w = 1'b1; bus_nb = 4'd0; bus_ad = 16'h0020; bus_dt_in = 16'h3333;
    repeat (2) begin @(posedge clk_sys); @(negedge clk_sys); end
    bus_w = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (bus_ok || bus_en) seen = 1'b1;
    end
    chk("acc_noans", {seen, busy}, 2'b00);
    txn(mk(0,1,0, 4'd0, 16'h0020, 16'h0, 1,0, LOK, 16'h3333), "acc_rd");

    // Reset while holding an answer: outputs drop at once, map returns to reset.
    txn(mk(1,0,1, 4'd0, 16'h0000, 16'h1251, 1,0, 2, 16'h0), "cfg5");
    bus_w = 1'b1; bus_nb = 4'd5; bus_ad = 16'h1000; bus_dt_in = 16'h7777;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      seen = bus_ok;
    end
    chk("clr_pre_ok", seen, 1'b1);
    #2 clr = 1'b1;
    #1 chk("clr_async", {bus_ok, bus_en, busy, bus_dt_out}, 32'h0);
    bus_w = 1'b0;
    @(negedge clk_sys);
    clr = 1'b0;
    @(negedge clk_sys);
    txn(mk(1,0,0, 4'd5, 16'h1000, 16'h7777, 0,1, 2,   16'h0),    "clr_map");
    txn(mk(0,1,0, 4'd0, 16'h0005, 16'h0,    1,0, LOK, 16'h5555), "clr_seg0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
